// File: rtl/controller_if.sv
// rtl/controller_if.sv - control bus between the multi-cycle controller and its datapath
interface controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/controller.sv
// rtl/controller.sv - multi-cycle ARM-subset control unit: decoder, Moore FSM, NZCV flags, condition check
module controller (
    input  logic         clk,
    input  logic         reset,
    controller_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;   // {N, Z, C, V}
    logic        condex_q, condex_d;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic        rd_pc;
    logic        cond_ex;
    logic        is_cmp;
    logic        is_arith;
    logic [3:0]  alu_ctl;

    assign cond     = bus.Instr[19:16];
    assign op       = bus.Instr[15:14];
    assign funct    = bus.Instr[13:8];
    assign cmd      = funct[4:1];
    assign rd_pc    = (bus.Instr[3:0] == 4'b1111);
    assign is_cmp   = (cmd == 4'b1010);

    // Condition evaluation against the architectural flags
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = ~(~z & (n == v));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing command to ALU operation; C/V only meaningful for arithmetic ops
    always_comb begin
        alu_ctl  = 4'b0000;
        is_arith = 1'b0;
        case (cmd)
            4'b0100: begin alu_ctl = 4'b0000; is_arith = 1'b1; end
            4'b0010: begin alu_ctl = 4'b0010; is_arith = 1'b1; end
            4'b1010: begin alu_ctl = 4'b0010; is_arith = 1'b1; end
            4'b0000: alu_ctl = 4'b0100;
            4'b1100: alu_ctl = 4'b0101;
            default: alu_ctl = 4'b0000;
        endcase
    end

    // Next state and Moore outputs; architectural writes gated by the latched condition
    always_comb begin
        state_d        = state_q;
        bus.PCWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 4'b0000;
        bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
        bus.ImmSrc     = op;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_d     = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = condex_q;
                bus.PCWrite   = condex_q & rd_pc;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = condex_q;
                state_d      = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUControl = alu_ctl;
                state_d        = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_ctl;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = condex_q & ~is_cmp;
                bus.PCWrite  = condex_q & rd_pc;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA   = 2'b10;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = condex_q;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Condition latch at end of DECODE and flag update at end of execute
    always_comb begin
        condex_d = condex_q;
        flags_d  = flags_q;
        if (state_q == S_DECODE) begin
            condex_d = cond_ex;
        end
        if ((state_q == S_EXECR || state_q == S_EXECI) && funct[0] && condex_q) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (is_arith) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end
        end
    end

    // State, flag and condition registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end
endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - randomized self-checking bench for controller against an instruction-level model
module tb_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    controller_if intf ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [3:0]  m_flags;        // model NZCV
    logic [18:0] exp_q[$];
    logic [3:0]  alf_q[$];
    logic [18:0] obs_q[$];

    logic [18:0] obs;
    assign obs = {intf.PCWrite, intf.MemWrite, intf.RegWrite, intf.IRWrite, intf.AdrSrc,
                  intf.RegSrc, intf.ALUSrcA, intf.ALUSrcB, intf.ResultSrc, intf.ImmSrc,
                  intf.ALUControl};

    function automatic logic [18:0] pack(input logic pcw, input logic mw, input logic rw,
                                         input logic irw, input logic adr, input logic [1:0] sa,
                                         input logic [1:0] sb, input logic [1:0] rs,
                                         input logic [3:0] ac, input logic [31:0] ins);
        logic [1:0] op;
        logic [1:0] regsrc;
        op = ins[27:26];
        regsrc = {(op == 2'd1) && !ins[20], op == 2'd2};
        return {pcw, mw, rw, irw, adr, regsrc, sa, sb, rs, op, ac};
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    // Builds the expected per-cycle control words for one whole instruction
    task automatic model_instr(input logic [31:0] ins, input logic [3:0] alf_exec);
        logic [1:0] op;
        logic [3:0] cmd;
        logic       ok, s, rd15, arith;
        logic [3:0] ac;
        exp_q.delete();
        alf_q.delete();
        op   = ins[27:26];
        cmd  = ins[24:21];
        s    = ins[20];
        rd15 = (ins[15:12] == 4'hF);
        ok   = cond_holds(ins[31:28], m_flags);
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        ac = (cmd == 4'b0010 || cmd == 4'b1010) ? 4'b0010 :
             (cmd == 4'b0000) ? 4'b0100 : (cmd == 4'b1100) ? 4'b0101 : 4'b0000;
        exp_q.push_back(pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins));
        exp_q.push_back(pack(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins));
        alf_q.push_back(4'($urandom));
        alf_q.push_back(4'($urandom));
        if (op == 2'd1) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'h0, ins));
            if (s) begin
                exp_q.push_back(pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, ins));
                exp_q.push_back(pack(ok && rd15, 0, ok, 0, 0, 2'b00, 2'b00, 2'b01, 4'h0, ins));
            end else begin
                exp_q.push_back(pack(0, ok, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, ins));
            end
        end else if (op == 2'd0) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 2'b00, ins[25] ? 2'b01 : 2'b00, 2'b00, ac, ins));
            exp_q.push_back(pack(ok && rd15, 0, ok && (cmd != 4'b1010), 0, 0,
                                 2'b00, 2'b00, 2'b00, 4'h0, ins));
            if (s && ok) begin
                m_flags[3:2] = alf_exec[3:2];
                if (arith) m_flags[1:0] = alf_exec[1:0];
            end
        end else if (op == 2'd2) begin
            exp_q.push_back(pack(ok, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 4'h0, ins));
        end
        while (alf_q.size() < exp_q.size()) begin
            alf_q.push_back((alf_q.size() == 2 && op == 2'd0) ? alf_exec : 4'($urandom));
        end
    endtask

    // Drives one instruction cycle by cycle from a negedge where the DUT is in FETCH
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] alf_exec);
        model_instr(ins, alf_exec);
        obs_q.delete();
        intf.Instr = ins[31:12];
        for (int i = 0; i < exp_q.size(); i++) begin
            intf.ALUFlags = alf_q[i];
            #1;
            obs_q.push_back(obs);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        ins = 32'hE5902060;
        intf.Instr = ins[31:12];
        intf.ALUFlags = 4'hF;
        apply_reset();
        #1;
        tests++;
        if (obs !== pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins)) begin
            fails++;
            $display("FAIL reset_fetch: got %h want %h", obs, pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins));
        end
        @(negedge clk);
        tests++;
        if (obs !== pack(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins)) begin
            fails++;
            $display("FAIL reset_decode: got %h", obs);
        end
        apply_reset();
    endtask

    task automatic test_directed();
        logic [31:0] prog[5];
        int lat[5];
        prog = '{32'hE04F000F, 32'hE5902060, 32'hE5837054, 32'hE2802005, 32'hEA000001};
        lat  = '{4, 5, 4, 4, 3};
        for (int k = 0; k < 5; k++) begin
            run_instr(prog[k], 4'($urandom));
            tests++;
            if (obs_q.size() !== lat[k]) begin
                fails++;
                $display("FAIL directed_len[%0d]: got %0d want %0d", k, obs_q.size(), lat[k]);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL directed[%0d] cyc %0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_condition();
        logic [31:0] prog[4];
        logic [3:0]  alf[4];
        logic [31:0] ins;
        // SUBS sets Z, BNE not taken, BEQ taken, then 1111 never
        prog = '{32'hE0510002, 32'h1A000001, 32'h0A000001, 32'hFA000001};
        alf  = '{4'b0100, 4'h0, 4'h0, 4'h0};
        for (int k = 0; k < 4; k++) begin
            run_instr(prog[k], alf[k]);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL cond[%0d] cyc %0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
                end
            end
        end
        tests++;
        if (obs_q[2][18] !== 1'b0) begin
            fails++;
            $display("FAIL cond_never_pcwrite: got %b want 0", obs_q[2][18]);
        end
        // Z set again, then reset in the middle of an LDR must clear it
        run_instr(32'hE0510002, 4'b0100);
        ins = 32'hE5902060;
        intf.Instr = ins[31:12];
        for (int i = 0; i < 3; i++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (obs !== pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 4'h0, ins)) begin
            fails++;
            $display("FAIL reset_mid_ldr: got %h", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
        run_instr(32'h0A000001, 4'h0);
        tests++;
        if (obs_q[2][18] !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags_cleared: beq pcwrite got %b want 0", obs_q[2][18]);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int k = 0; k < 150; k++) begin
            ins = $urandom;
            if (k % 5 == 0) ins[31:28] = 4'hE;
            if (k % 7 == 0) ins[15:12] = 4'hF;
            run_instr(ins, 4'($urandom));
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random[%0d] ins %h cyc %0d: got %h want %h", k, ins, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int k = 0; k < 40; k++) begin
            ins = {4'hE, 2'b00, 1'($urandom), 4'($urandom), 1'b1, 20'($urandom)};
            run_instr(ins, 4'($urandom));
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL b2b[%0d] ins %h cyc %0d: got %h want %h", k, ins, i, obs_q[i], exp_q[i]);
                end
            end
            ins = {4'($urandom), 2'b10, 26'($urandom)};
            run_instr(ins, 4'h0);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL b2b_br[%0d] ins %h cyc %0d: got %h want %h", k, ins, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        m_flags = 4'b0000;
        intf.Instr = 20'h0;
        intf.ALUFlags = 4'h0;
        test_reset();
        test_directed();
        test_condition();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
